// File: rtl/fb_stream_receiver.sv
// UART byte stream to frame-buffer receiver: assembles {R,G,B} pixels and writes
// them at sequential addresses, with write handshake, inter-byte timeout and sticky errors.
module fb_stream_receiver #(
    parameter int H_RES          = 1920,
    parameter int V_RES          = 1080,
    parameter int ADDR_W         = 21,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              clr_rx_rdy,
    output logic              fb_we,
    output logic [23:0]       fb_wdata,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic              fb_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow_err,
    output logic              timeout_err
);
    localparam int NUM_PIXELS = H_RES * V_RES;
    localparam int TO_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    state_t            r_state;
    logic [1:0]        r_byte_cnt;
    logic [15:0]       r_shift;
    logic [23:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pending;
    logic [TO_W-1:0]   r_tcnt;
    logic              r_ovf;
    logic              r_to;

    logic        w_pix_done;
    logic        w_accept;
    logic [23:0] w_pixel;

    assign w_pix_done = rx_rdy && (r_byte_cnt == 2'd2);
    assign w_accept   = r_pending && fb_ready;
    assign w_pixel    = {r_shift, rx_data};

    assign clr_rx_rdy   = rx_rdy;
    assign fb_we        = r_pending;
    assign fb_wdata     = r_wdata;
    assign fb_addr      = r_addr;
    assign busy         = (r_state == S_RECV);
    assign frame_done   = (r_state == S_DONE);
    assign overflow_err = r_ovf;
    assign timeout_err  = r_to;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_wdata    <= '0;
            r_addr     <= '0;
            r_pending  <= 1'b0;
            r_tcnt     <= '0;
            r_ovf      <= 1'b0;
            r_to       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rx_en) begin
                        r_state    <= S_RECV;
                        r_addr     <= '0;
                        r_byte_cnt <= '0;
                        r_pending  <= 1'b0;
                        r_tcnt     <= '0;
                        r_ovf      <= 1'b0;
                        r_to       <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (!rx_en) begin
                        r_state    <= S_IDLE;
                        r_byte_cnt <= '0;
                        r_pending  <= 1'b0;
                        r_tcnt     <= '0;
                    end else begin
                        if (rx_rdy) begin
                            r_shift    <= {r_shift[7:0], rx_data};
                            r_byte_cnt <= w_pix_done ? 2'd0 : r_byte_cnt + 2'd1;
                        end
                        // A byte arriving always beats the timeout; only idle partial pixels age.
                        if (rx_rdy || r_byte_cnt == 2'd0) begin
                            r_tcnt <= '0;
                        end else if (r_tcnt == TO_LAST) begin
                            r_tcnt     <= '0;
                            r_byte_cnt <= '0;
                            r_to       <= 1'b1;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                        if (w_accept && r_addr == LAST_ADDR) begin
                            r_state   <= S_DONE;
                            r_pending <= 1'b0;
                        end else if (w_accept) begin
                            r_addr    <= r_addr + 1'b1;
                            r_pending <= w_pix_done;
                            if (w_pix_done) r_wdata <= w_pixel;
                        end else if (w_pix_done) begin
                            if (r_pending) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_pending <= 1'b1;
                                r_wdata   <= w_pixel;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!rx_en) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_stream_receiver.sv
// Bench for fb_stream_receiver on a 4x2 frame: scoreboard of expected writes
// filled as pixels are sent and drained by a write monitor.
module tb_fb_stream_receiver;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int T  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_en = 1'b0;
    logic          rx_rdy = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          fb_ready = 1'b0;
    logic          clr_rx_rdy;
    logic          fb_we;
    logic [23:0]   fb_wdata;
    logic [AW-1:0] fb_addr;
    logic          busy;
    logic          frame_done;
    logic          overflow_err;
    logic          timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW+23:0] sb[$];
    logic [AW+23:0] mon_e;
    logic [AW-1:0]  exp_addr = '0;

    fb_stream_receiver #(
        .H_RES(H),
        .V_RES(V),
        .ADDR_W(AW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_en(rx_en),
        .rx_rdy(rx_rdy),
        .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy),
        .fb_we(fb_we),
        .fb_wdata(fb_wdata),
        .fb_addr(fb_addr),
        .fb_ready(fb_ready),
        .busy(busy),
        .frame_done(frame_done),
        .overflow_err(overflow_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Inputs change on negedge; writes are sampled 1 time unit before the accepting posedge.
    always begin
        @(negedge clk);
        #4;
        if (!rst && fb_we && fb_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", 32'(fb_addr), 32'(mon_e[AW+23:24]));
                check("wr_data", 32'(fb_wdata), 32'(mon_e[23:0]));
            end
        end
    end

    function automatic logic [23:0] px(input int k);
        logic [3:0] n;
        n = 4'(k);
        return {n, 4'h0, n, 4'h1, n, 4'h2};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic send_pixel(input logic [23:0] p, input bit expect_write, input logic pre_we);
        send_byte(p[23:16]);
        send_byte(p[15:8]);
        check("we_before_third", 32'(fb_we), 32'(pre_we));
        if (expect_write) begin
            sb.push_back({exp_addr, p});
            exp_addr = exp_addr + 1'b1;
        end
        send_byte(p[7:0]);
        check("we_after_third", 32'(fb_we), 32'd1);
    endtask

    task automatic arm();
        @(negedge clk);
        rx_en    = 1'b1;
        exp_addr = '0;
        @(negedge clk);
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_addr", 32'(fb_addr), 32'd0);
        check("arm_errs", {30'd0, overflow_err, timeout_err}, 32'd0);
    endtask

    task automatic disarm();
        @(negedge clk);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        check("disarm_busy", 32'(busy), 32'd0);
        check("disarm_we", 32'(fb_we), 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (frame_done) break;
            @(negedge clk);
        end
        check("frame_done", 32'(frame_done), 32'd1);
    endtask

    initial begin
        // Reset state, with clr_rx_rdy following rx_rdy.
        rst    = 1'b1;
        rx_rdy = 1'b1;
        #12;
        check("rst_outs", {fb_we, busy, frame_done, overflow_err, timeout_err}, 32'd0);
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_wdata", 32'(fb_wdata), 32'd0);
        check("rst_clr_hi", 32'(clr_rx_rdy), 32'd1);
        rx_rdy = 1'b0;
        #1;
        check("rst_clr_lo", 32'(clr_rx_rdy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Nominal frame.
        fb_ready = 1'b1;
        arm();
        for (int k = 0; k < H * V; k++) begin
            if (k == H * V - 1) check("nom_not_done_early", 32'(frame_done), 32'd0);
            send_pixel(px(k), 1'b1, 1'b0);
        end
        wait_done();
        check("nom_busy", 32'(busy), 32'd0);
        check("nom_last_addr", 32'(fb_addr), 32'(H * V - 1));
        check("nom_errs", {30'd0, overflow_err, timeout_err}, 32'd0);
        send_byte(8'h77);
        check("done_we", 32'(fb_we), 32'd0);
        check("done_holds", 32'(frame_done), 32'd1);
        disarm();
        check("idle_done", 32'(frame_done), 32'd0);

        // Backpressure and overflow.
        arm();
        fb_ready = 1'b0;
        send_pixel(24'h112233, 1'b1, 1'b0);
        send_pixel(24'h445566, 1'b0, 1'b1);
        check("ovf_flag", 32'(overflow_err), 32'd1);
        check("ovf_hold_addr", 32'(fb_addr), 32'd0);
        check("ovf_hold_data", 32'(fb_wdata), 32'h112233);
        @(negedge clk);
        fb_ready = 1'b1;
        @(negedge clk);
        send_pixel(24'h778899, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("ovf_sticky", 32'(overflow_err), 32'd1);
        disarm();
        check("ovf_sticky_idle", 32'(overflow_err), 32'd1);

        // Accept of the held pixel in the same cycle as the next pixel completes.
        arm();
        fb_ready = 1'b0;
        send_pixel(24'hA1A2A3, 1'b1, 1'b0);
        send_byte(8'hB1);
        send_byte(8'hB2);
        sb.push_back({exp_addr, 24'hB1B2B3});
        exp_addr = exp_addr + 1'b1;
        @(negedge clk);
        rx_rdy   = 1'b1;
        rx_data  = 8'hB3;
        fb_ready = 1'b1;
        @(negedge clk);
        rx_rdy = 1'b0;
        check("same_we", 32'(fb_we), 32'd1);
        check("same_addr", 32'(fb_addr), 32'd1);
        repeat (2) @(negedge clk);
        check("same_no_ovf", 32'(overflow_err), 32'd0);
        disarm();

        // Inter-byte timeout.
        arm();
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (T) @(negedge clk);
        check("to_flag", 32'(timeout_err), 32'd1);
        send_pixel(24'hAABBCC, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("to_sticky", 32'(timeout_err), 32'd1);
        disarm();

        // Abort after four pixels, then a complete frame.
        arm();
        for (int k = 0; k < 4; k++) send_pixel(px(k + 8), 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        disarm();
        check("abort_no_done", 32'(frame_done), 32'd0);
        arm();
        for (int k = 0; k < H * V; k++) begin
            if (k == H * V - 1) check("rearm_not_done", 32'(frame_done), 32'd0);
            send_pixel(px(k + 8), 1'b1, 1'b0);
        end
        wait_done();
        disarm();

        // Asynchronous reset between pixel bytes.
        arm();
        send_byte(8'h99);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_outs", {fb_we, busy, frame_done, overflow_err, timeout_err}, 32'd0);
        check("arst_addr", 32'(fb_addr), 32'd0);
        check("arst_wdata", 32'(fb_wdata), 32'd0);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_byte(8'h98);
        send_byte(8'h97);
        check("arst_idle_we", 32'(fb_we), 32'd0);
        check("arst_idle_busy", 32'(busy), 32'd0);
        arm();
        send_pixel(24'hDEADBE, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        disarm();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fb_stream_receiver.md
Name: fb_stream_receiver

Overview:
- Host-side-facing receiver for the UART frame-buffer stream: reassembles 3-byte RGB pixels (R first, then G, then B) from a UART byte interface.
- Writes each pixel to a frame-buffer write port at sequential addresses 0..H_RES*V_RES-1, then flags frame completion.
- Sits between a UART RX byte interface and a frame-buffer/display memory. It is the loopback/display-side counterpart of the on-board frame-buffer transmitter.
- Adds a write-port handshake, inter-byte timeout resync and sticky error flags.

Parameters:
- H_RES, 1920, pixels per line.
- V_RES, 1080, lines per frame; NUM_PIXELS = H_RES*V_RES.
- ADDR_W, 21, frame-buffer address width; must satisfy 2**ADDR_W >= NUM_PIXELS.
- TIMEOUT_CYCLES, 1_000_000, idle clk cycles allowed between bytes of one pixel before the partial pixel is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- rx_en  in  1  level: arms and holds a frame reception.
- rx_rdy  in  1  UART byte valid.
- rx_data  in  8  UART byte.
- clr_rx_rdy  out  1  acknowledge to UART; equals rx_rdy combinationally in every state.
- fb_we  out  1  frame-buffer write request.
- fb_wdata  out  24  pixel {R,G,B}, with R in [23:16].
- fb_addr  out  ADDR_W  write address.
- fb_ready  in  1  frame-buffer accepts a write this cycle.
- busy  out  1  high in RECV.
- frame_done  out  1  high in DONE.
- overflow_err  out  1  sticky: a pixel was dropped due to backpressure.
- timeout_err  out  1  sticky: a partial pixel was discarded.

Behaviour:
- Reset (async, rst=1): state IDLE; byte_cnt=0; pending=0; fb_addr=0; fb_wdata=0; timeout counter=0. All outputs 0 except clr_rx_rdy, which follows rx_rdy.
- States: IDLE, RECV, DONE.
- IDLE:
  - Incoming bytes are acknowledged and discarded.
  - rx_en=1 → RECV next cycle. On that transition: fb_addr=0, byte_cnt=0, pending=0, overflow_err=0, timeout_err=0.
- RECV, byte assembly:
  - On each rx_rdy: shift reg <= {shift[15:0], rx_data}; byte_cnt increments 0→1→2.
  - On the byte with byte_cnt==2: byte_cnt<=0, fb_wdata <= {shift[15:0], rx_data}, pending<=1.
  - Latency: third byte in cycle N → fb_we=1 in cycle N+1.
- RECV, write handshake:
  - fb_we = pending.
  - A write completes in any cycle with fb_we & fb_ready. fb_addr, fb_wdata and fb_we are held stable until accepted.
  - On completion: fb_addr+1 and pending clears, unless a new pixel completes the same cycle, in which case the new pixel loads and pending stays 1.
  - Overflow: a pixel completes while pending=1 and fb_ready=0 → new pixel dropped, overflow_err<=1, held pixel and address unchanged.
- RECV, timeout:
  - While byte_cnt!=0 and rx_rdy=0, the counter increments. It clears on rx_rdy or when byte_cnt==0.
  - Counter reaching TIMEOUT_CYCLES-1 → byte_cnt<=0, counter<=0, timeout_err<=1. fb_addr and pending are not affected.
  - rx_rdy in the same cycle takes priority over timeout.
- RECV, frame end: write accepted at fb_addr==NUM_PIXELS-1 → DONE. fb_addr is not incremented past NUM_PIXELS-1; it is cleared on the next arm.
- RECV, abort: rx_en=0 → IDLE next cycle. Partial pixel and any pending write are discarded (fb_we=0 from next cycle); frame_done stays 0.
- DONE:
  - frame_done=1, busy=0, fb_we=0; bytes are discarded.
  - rx_en=0 → IDLE. rx_en held high stays in DONE; no re-arm without a low phase.
- Error flags hold through DONE and IDLE until the next arm or reset.
- Width rules: byte_cnt 2 bits, never reaches 3. The timeout counter is sized $clog2(TIMEOUT_CYCLES).
- Mid-operation reset: immediate return to reset values; no write is issued after rst asserts.

Test Plan:
Simulate with H_RES=4, V_RES=2, TIMEOUT_CYCLES=16.
- Nominal frame: rx_en=1, fb_ready=1, stream 24 bytes (pixel k = {8'hk0, 8'hk1, 8'hk2}). Required:
  - 8 writes at addr 0..7, pixel 0 data 24'h000102.
  - fb_we one cycle after each third byte.
  - frame_done=1 after addr 7; no errors.
- Backpressure/overflow: fb_ready=0 across two complete pixels. Required:
  - First pixel held at addr 0, second dropped, overflow_err=1.
  - Raising fb_ready writes the held pixel at addr 0, then addr 1 for the next pixel.
- Same-cycle accept and complete: a third byte arrives in the cycle fb_ready accepts the pending pixel. Required: both pixels written, at consecutive addresses, with no overflow.
- Timeout: send 2 bytes, idle 16 cycles, then send 3 bytes AA,BB,CC. Required: timeout_err=1; write 24'hAABBCC at addr 0.
- Abort and re-arm: drop rx_en after 4 pixels, then raise again and send a full frame. Required:
  - Writes restart at addr 0 and flags clear.
  - frame_done only at the end of the second frame.
- Async reset mid-pixel: assert rst between bytes 1 and 2. Required: all outputs 0 immediately; state IDLE; no fb_we until re-armed.
